clahe_interp_weight: RTL

Upstream neighbour of the CLAHE equalizer stage. It tracks the (x,y) position of each incoming pixel in raster order and derives the four surrounding tile indices used to address the per-tile mapping RAMs. It also computes the four bilinear interpolation weights (Q20 fixed point). Pixel data, syncs, weights and tile indices leave the block mutually aligned, ready for the equalizer.

---
 rtl/clahe_interp_weight.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/clahe_interp_weight.sv
// Raster position tracker and bilinear tile-weight generator feeding the CLAHE equalizer.
// Build option: define CLAHE_WSUM_FIX_EN to derive w4 so the four weights sum to exactly 2^20.
module clahe_interp_weight #(
  parameter  int IMG_W   = 640,
  parameter  int IMG_H   = 480,
  parameter  int TILE_NX = 8,
  parameter  int TILE_NY = 8,
  localparam int IDX_W   = $clog2(TILE_NX * TILE_NY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_H_SYNC,
  input  logic             in_V_SYNC,
  input  logic             in_data_en,
  input  logic             TVALID_in,
  input  logic [7:0]       data_in,
  output logic             o_H_SYNC,
  output logic             o_V_SYNC,
  output logic             o_data_en,
  output logic [7:0]       data_out,
  output logic [IDX_W-1:0] tile_idx1,
  output logic [IDX_W-1:0] tile_idx2,
  output logic [IDX_W-1:0] tile_idx3,
  output logic [IDX_W-1:0] tile_idx4,
  output logic [21:0]      w1,
  output logic [21:0]      w2,
  output logic [21:0]      w3,
  output logic [21:0]      w4,
  output logic             inter_complete
);

  localparam int TW    = IMG_W / TILE_NX;
  localparam int TH    = IMG_H / TILE_NY;
  localparam int RECIP = ((1 << 20) + TW * TH / 2) / (TW * TH);
  localparam int XW    = $clog2(IMG_W);
  localparam int YW    = $clog2(IMG_H);
  localparam int FXW   = $clog2(TW + 1);
  localparam int FYW   = $clog2(TH + 1);
  localparam int CXW   = $clog2(TILE_NX);
  localparam int CYW   = $clog2(TILE_NY);
  localparam int RW    = $clog2(RECIP + 1);
  localparam int PW    = FXW + FYW + RW;
  localparam int WW    = 22;

  localparam logic [XW-1:0]  X_MAX  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_MAX  = YW'(IMG_H - 1);
  localparam logic [XW-1:0]  X_HALF = XW'(TW / 2);
  localparam logic [YW-1:0]  Y_HALF = YW'(TH / 2);
  localparam logic [FXW-1:0] PX_MAX = FXW'(TW - 1);
  localparam logic [FYW-1:0] PY_MAX = FYW'(TH - 1);
  localparam logic [CXW-1:0] C_MAX  = CXW'(TILE_NX - 1);
  localparam logic [CYW-1:0] R_MAX  = CYW'(TILE_NY - 1);

  function automatic logic [IDX_W-1:0] idx_of(input logic [CYW-1:0] row, input logic [CXW-1:0] col);
    return IDX_W'(row) * IDX_W'(TILE_NX) + IDX_W'(col);
  endfunction

  // Position counters: phx/col track (x - TW/2) mod / div TW incrementally, likewise phy/row.
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [FXW-1:0] phx_q, phx_d;
  logic [FYW-1:0] phy_q, phy_d;
  logic [CXW-1:0] col_q, col_d;
  logic [CYW-1:0] row_q, row_d;
  logic           de_prev_q, vs_prev_q;

  logic             s1_de_q, s1_hs_q, s1_vs_q, s1_last_q;
  logic [7:0]       s1_data_q;
  logic [FXW-1:0]   s1_fx_q;
  logic [FYW-1:0]   s1_fy_q;
  logic [IDX_W-1:0] s1_idx1_q, s1_idx2_q, s1_idx3_q, s1_idx4_q;

  logic             hs_q, vs_q, de_q, ic_q;
  logic [7:0]       data_q;
  logic [IDX_W-1:0] idx1_q, idx2_q, idx3_q, idx4_q;
  logic [WW-1:0]    w1_q, w2_q, w3_q, w4_q;

  logic vs_rise, de_fall;
  assign vs_rise = in_V_SYNC & ~vs_prev_q;
  assign de_fall = ~in_data_en & de_prev_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    phx_d = phx_q;
    phy_d = phy_q;
    col_d = col_q;
    row_d = row_q;
    if (vs_rise) begin
      x_d = '0; y_d = '0; phx_d = '0; phy_d = '0; col_d = '0; row_d = '0;
    end else if (de_fall) begin
      x_d = '0; phx_d = '0; col_d = '0;
      if (y_q < Y_MAX) begin
        y_d = y_q + YW'(1);
        if (y_q >= Y_HALF) begin
          if (phy_q == PY_MAX) begin
            phy_d = '0;
            row_d = row_q + CYW'(1);
          end else begin
            phy_d = phy_q + FYW'(1);
          end
        end
      end
    end else if (in_data_en && (x_q < X_MAX)) begin
      x_d = x_q + XW'(1);
      if (x_q >= X_HALF) begin
        if (phx_q == PX_MAX) begin
          phx_d = '0;
          col_d = col_q + CXW'(1);
        end else begin
          phx_d = phx_q + FXW'(1);
        end
      end
    end
  end

  // Left half-tile and last tile both collapse onto a single tile with zero fraction.
  logic           x_edge, y_edge, last_c;
  logic [CXW-1:0] cr_c;
  logic [CYW-1:0] rb_c;
  logic [FXW-1:0] fx_c;
  logic [FYW-1:0] fy_c;
  assign x_edge = (x_q < X_HALF) || (col_q == C_MAX);
  assign y_edge = (y_q < Y_HALF) || (row_q == R_MAX);
  assign cr_c   = x_edge ? col_q : col_q + CXW'(1);
  assign rb_c   = y_edge ? row_q : row_q + CYW'(1);
  assign fx_c   = x_edge ? '0 : phx_q;
  assign fy_c   = y_edge ? '0 : phy_q;
  assign last_c = in_data_en && (x_q == X_MAX) && (y_q == Y_MAX);

  logic [FXW-1:0] fxn;
  logic [FYW-1:0] fyn;
  logic [PW-1:0]  p1, p2, p3, p4;
  logic [WW-1:0]  w1_c, w2_c, w3_c, w4_c;
  assign fxn  = FXW'(TW) - s1_fx_q;
  assign fyn  = FYW'(TH) - s1_fy_q;
  assign p1   = PW'(fxn) * PW'(fyn) * PW'(RECIP);
  assign p2   = PW'(s1_fx_q) * PW'(fyn) * PW'(RECIP);
  assign p3   = PW'(fxn) * PW'(s1_fy_q) * PW'(RECIP);
  assign p4   = PW'(s1_fx_q) * PW'(s1_fy_q) * PW'(RECIP);
  assign w1_c = WW'(p1);
  assign w2_c = WW'(p2);
  assign w3_c = WW'(p3);
`ifdef CLAHE_WSUM_FIX_EN
  assign w4_c = WW'(1 << 20) - w1_c - w2_c - w3_c;
`else
  assign w4_c = WW'(p4);
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0; y_q <= '0; phx_q <= '0; phy_q <= '0; col_q <= '0; row_q <= '0;
      de_prev_q <= 1'b0; vs_prev_q <= 1'b0;
      s1_de_q <= 1'b0; s1_hs_q <= 1'b0; s1_vs_q <= 1'b0; s1_last_q <= 1'b0;
      s1_data_q <= '0; s1_fx_q <= '0; s1_fy_q <= '0;
      s1_idx1_q <= '0; s1_idx2_q <= '0; s1_idx3_q <= '0; s1_idx4_q <= '0;
      hs_q <= 1'b0; vs_q <= 1'b0; de_q <= 1'b0; ic_q <= 1'b0; data_q <= '0;
      idx1_q <= '0; idx2_q <= '0; idx3_q <= '0; idx4_q <= '0;
      w1_q <= '0; w2_q <= '0; w3_q <= '0; w4_q <= '0;
    end else begin
      // Single-cycle pulse: cleared on any following cycle, stalled or not.
      ic_q <= TVALID_in & s1_last_q;
      if (TVALID_in) begin
        vs_prev_q <= in_V_SYNC;
        de_prev_q <= in_data_en;
        x_q <= x_d; y_q <= y_d; phx_q <= phx_d; phy_q <= phy_d; col_q <= col_d; row_q <= row_d;
        s1_de_q   <= in_data_en;
        s1_hs_q   <= in_H_SYNC;
        s1_vs_q   <= in_V_SYNC;
        s1_data_q <= data_in;
        s1_last_q <= last_c;
        s1_fx_q   <= fx_c;
        s1_fy_q   <= fy_c;
        s1_idx1_q <= idx_of(row_q, col_q);
        s1_idx2_q <= idx_of(row_q, cr_c);
        s1_idx3_q <= idx_of(rb_c, col_q);
        s1_idx4_q <= idx_of(rb_c, cr_c);
        hs_q   <= s1_hs_q;
        vs_q   <= s1_vs_q;
        de_q   <= s1_de_q;
        data_q <= s1_data_q;
        idx1_q <= s1_de_q ? s1_idx1_q : '0;
        idx2_q <= s1_de_q ? s1_idx2_q : '0;
        idx3_q <= s1_de_q ? s1_idx3_q : '0;
        idx4_q <= s1_de_q ? s1_idx4_q : '0;
        w1_q   <= s1_de_q ? w1_c : '0;
        w2_q   <= s1_de_q ? w2_c : '0;
        w3_q   <= s1_de_q ? w3_c : '0;
        w4_q   <= s1_de_q ? w4_c : '0;
      end
    end
  end

  assign o_H_SYNC       = hs_q;
  assign o_V_SYNC       = vs_q;
  assign o_data_en      = de_q;
  assign data_out       = data_q;
  assign tile_idx1      = idx1_q;
  assign tile_idx2      = idx2_q;
  assign tile_idx3      = idx3_q;
  assign tile_idx4      = idx4_q;
  assign w1             = w1_q;
  assign w2             = w2_q;
  assign w3             = w3_q;
  assign w4             = w4_q;
  assign inter_complete = ic_q;

endmodule
